lc3b_mem_arbiter: RTL and testbench
===================================

# lc3b_mem_arbiter

Shares the single physical memory port between the pipeline's instruction-fetch requester and its data-memory requester. Every transaction uses a hold-until-response handshake. The arbiter sits between the pipelined datapath's instruction and data memory interfaces and the memory (or cache) below. It registers the granted request and forwards exactly one transaction at a time. It routes the response back only to the requester that owns the grant.

## Interface
- WIDTH, 16, address and data width in bits (lc3b_word)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  instruction fetch request, held until i_resp
- i_address  in  WIDTH  fetch address
- i_rdata  out  WIDTH  fetch data, valid while i_resp=1
- i_resp  out  1  fetch complete, one cycle
- d_read  in  1  data read request, held until d_resp
- d_write  in  1  data write request, held until d_resp
- d_wmask  in  2  byte enables for write (lc3b_mem_wmask)
- d_address  in  WIDTH  data address
- d_wdata  in  WIDTH  write data
- d_rdata  out  WIDTH  read data, valid while d_resp=1
- d_resp  out  1  data transaction complete, one cycle
- pmem_read  out  1  read to physical memory
- pmem_write  out  1  write to physical memory
- pmem_wmask  out  2  byte enables
- pmem_address  out  WIDTH  physical address
- pmem_wdata  out  WIDTH  physical write data
- pmem_rdata  in  WIDTH  physical read data
- pmem_resp  in  1  physical transaction complete

## Operation
- The FSM has three states: IDLE, I_BUSY and D_BUSY. Reset state is IDLE.
- IDLE behaviour:
  - With no request, stay in IDLE.
  - With a request, capture the winner's address, wdata, wmask and op into the internal request register, then enter I_BUSY or D_BUSY.
- Arbitration in IDLE depends on the configuration below. A lone requester always wins.
- Busy behaviour (I_BUSY or D_BUSY):
  - pmem_* is driven only from the captured register. Requester inputs changing mid-transaction have no effect.
  - The state stays put until pmem_resp=1. On that edge the state returns to IDLE.
- Response routing:
  - i_resp = pmem_resp & (state==I_BUSY), combinational.
  - d_resp = pmem_resp & (state==D_BUSY), combinational.
  - i_rdata and d_rdata = pmem_rdata, passed through unconditionally.
- pmem_resp seen in IDLE is ignored.
- If d_read and d_write are both asserted, the request is treated as a write.
- d_wmask is forwarded only on writes. pmem_wmask = 2'b00 on reads.
- A request still asserted in the cycle after its resp is treated as a new request.

## Timing
- Reset value of every output is 0. The internal request register also resets to 0.
- Request latency:
  - Request high during cycle k, state IDLE → pmem_read or pmem_write is high from cycle k+1. pmem_* outputs are registered (Moore).
  - pmem_resp in cycle m → i_resp or d_resp in cycle m, same cycle → pmem_read and pmem_write are low in cycle m+1.
  - Minimum request-to-request gap is therefore one IDLE cycle. Back-to-back throughput is one transaction per (memory latency + 1) cycles.
- Reset asserted mid-transaction:
  - The transaction is aborted immediately (asynchronous) and all outputs clear.
  - The requester must reissue the request after reset.
- A requester that loses arbitration keeps its request asserted. It is granted in the IDLE cycle after the winner's resp, subject to the priority rule.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Add a 1-bit last_grant register; reset value is data.
  - On simultaneous requests, grant the side not in last_grant, then update last_grant.
  - The first contention after reset therefore goes to instruction.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: data always wins simultaneous requests.
  - The last_grant register is not present.

## Structure
- The shared package lc3b_types gains:
  - lc3b_mem_wmask (logic [1:0]).
  - lc3b_arb_state enum {IDLE, I_BUSY, D_BUSY}.
  - lc3b_arb_req struct {read, write, wmask, address, wdata} for the captured request.
- No sub-module. The block is a single module containing the FSM, the request register and the response routing.

## Test plan
- Lone fetch:
  - Stimulus: i_read=1, i_address=16'h0040; pmem_resp after 3 cycles with rdata=16'h1234.
  - Required: pmem_read=1 starting the cycle after the request, pmem_address=16'h0040; i_resp=1 with i_rdata=16'h1234 in exactly one cycle; d_resp never 1.
- Lone byte write:
  - Stimulus: d_write=1, d_wmask=2'b10, d_address=16'h0102, d_wdata=16'hAB00.
  - Required: pmem_write=1, pmem_wmask=2'b10, pmem_address=16'h0102, pmem_wdata=16'hAB00; d_resp on pmem_resp; pmem_write=0 the next cycle.
- Contention:
  - Stimulus: i_read and d_read asserted together, repeated twice.
  - Required, macro undefined: data granted both times, then instruction.
  - Required, macro defined: instruction granted first, then data, then instruction.
- Input change during transaction:
  - Stimulus: change d_address from 16'h0010 to 16'h0020 while in D_BUSY.
  - Required: pmem_address stays at 16'h0010 until resp.
- Reset mid-transaction:
  - Stimulus: assert reset in I_BUSY.
  - Required: all outputs 0 immediately; after reset release with i_read still held, a fresh fetch starts one cycle later.
- Spurious response:
  - Stimulus: pmem_resp=1 while IDLE.
  - Required: no i_resp or d_resp; state remains IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, byte-enable mask, memory arbiter state and captured request.
package lc3b_types;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned WMASK_WIDTH = 2;

    typedef logic [WIDTH-1:0]       lc3b_word;
    typedef logic [WMASK_WIDTH-1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } lc3b_arb_state;

    typedef struct packed {
        logic          read;
        logic          write;
        lc3b_mem_wmask wmask;
        lc3b_word      address;
        lc3b_word      wdata;
    } lc3b_arb_req;

endpackage

// File: rtl/lc3b_mem_arbiter.sv
// Memory arbiter: shares one physical memory port between instruction fetch and
// data access, one transaction at a time, hold-until-response handshake.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of
// fixed data priority.
module lc3b_mem_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,

    input  logic          i_read,
    input  lc3b_word      i_address,
    output lc3b_word      i_rdata,
    output logic          i_resp,

    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_mem_wmask d_wmask,
    input  lc3b_word      d_address,
    input  lc3b_word      d_wdata,
    output lc3b_word      d_rdata,
    output logic          d_resp,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_mem_wmask pmem_wmask,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);

    lc3b_arb_state state_q, state_d;
    lc3b_arb_req   req_q,   req_d;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic last_grant_q, last_grant_d;

    // Data wins when alone, or on contention when instruction was served last.
    always_comb begin
        grant_d = d_req & (~i_req | (last_grant_q == GRANT_I));
    end

    // Remember which side was granted most recently.
    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && (i_req | d_req)) begin
            last_grant_d = grant_d ? GRANT_D : GRANT_I;
        end
    end

    // Last-grant register; starts at data so the first contention goes to instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: any data request beats an instruction request.
    always_comb begin
        grant_d = d_req;
    end
`endif

    // Next state and request-register update.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d       = D_BUSY;
                    req_d.write   = d_write;
                    req_d.read    = ~d_write;
                    req_d.wmask   = d_write ? d_wmask : lc3b_mem_wmask'(0);
                    req_d.address = d_address;
                    req_d.wdata   = d_wdata;
                end else if (i_req) begin
                    state_d       = I_BUSY;
                    req_d.write   = 1'b0;
                    req_d.read    = 1'b1;
                    req_d.wmask   = lc3b_mem_wmask'(0);
                    req_d.address = i_address;
                    req_d.wdata   = lc3b_word'(0);
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                    req_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    // State and captured request registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Physical port is driven straight from the captured request register.
    assign pmem_read    = req_q.read;
    assign pmem_write   = req_q.write;
    assign pmem_wmask   = req_q.wmask;
    assign pmem_address = req_q.address;
    assign pmem_wdata   = req_q.wdata;

    // Response goes only to the grant owner; read data is shared.
    assign i_resp  = pmem_resp & (state_q == I_BUSY);
    assign d_resp  = pmem_resp & (state_q == D_BUSY);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed, table-driven bench for lc3b_mem_arbiter plus a contention sequence.
module tb_lc3b_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_read;
    logic [15:0] i_address;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [1:0]  d_wmask;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int checks = 0;
    int errors = 0;

    lc3b_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_wmask      (d_wmask),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wmask   (pmem_wmask),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [1:0]  wm;
        logic [15:0] da;
        logic [15:0] dwd;
        logic [15:0] prd;
        logic        presp;
        logic        e_rd;
        logic        e_wr;
        logic [1:0]  e_wm;
        logic [15:0] e_addr;
        logic [15:0] e_wd;
        logic        e_iresp;
        logic        e_dresp;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pmem_read"},  16'(pmem_read),  16'h0);
        chk({tag, "_pmem_write"}, 16'(pmem_write), 16'h0);
        chk({tag, "_pmem_wmask"}, 16'(pmem_wmask), 16'h0);
        chk({tag, "_pmem_addr"},  pmem_address,    16'h0);
        chk({tag, "_pmem_wdata"}, pmem_wdata,      16'h0);
        chk({tag, "_i_resp"},     16'(i_resp),     16'h0);
        chk({tag, "_d_resp"},     16'(d_resp),     16'h0);
    endtask

    logic        exp_is_i [3];
    int          rem_i;
    int          rem_d;
    logic        found;
    logic        got_i;

    initial begin
        //        rst   ir    ia        dr    dw    wm     da        dwd       prd       presp | rd    wr    wm     addr      wdata     iresp dresp
        // lone fetch, 3-cycle memory latency
        tbl[0]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        // lone byte write
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'b10, 16'h0102, 16'hAB00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'b10, 16'h0102, 16'hAB00, 16'h0000, 1'b0, 1'b0, 1'b1, 2'b10, 16'h0102, 16'hAB00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'b10, 16'h0102, 16'hAB00, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0102, 16'hAB00, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        // data read with address change mid-transaction; read forwards no wmask
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b11, 16'h0010, 16'h7777, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b11, 16'h0020, 16'h7777, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h7777, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b11, 16'h0020, 16'h7777, 16'hBEEF, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h7777, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        // spurious response while idle
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        // fetch then reset while I_BUSY, then re-fetch after release
        tbl[14] = '{1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0050, 16'h0000, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 16'h0050, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0050, 16'h0000, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h4242, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0050, 16'h0000, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        // read and write together: treated as a write
        tbl[21] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2'b01, 16'h0200, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2'b01, 16'h0200, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0200, 16'h5555, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2'b01, 16'h0200, 16'h5555, 16'h9999, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0200, 16'h5555, 1'b0, 1'b1};
        tbl[24] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};

        reset      = 1'b1;
        i_read     = 1'b0;
        i_address  = 16'h0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_wmask    = 2'b00;
        d_address  = 16'h0;
        d_wdata    = 16'h0;
        pmem_rdata = 16'h0;
        pmem_resp  = 1'b0;

        // Reset state, with a request pending that must not be captured.
        @(negedge clk);
        i_read = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        i_read = 1'b0;
        reset  = 1'b0;

        // Vector table: drive at falling edge, compare shortly after.
        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            reset      = tbl[n].rst;
            i_read     = tbl[n].ir;
            i_address  = tbl[n].ia;
            d_read     = tbl[n].dr;
            d_write    = tbl[n].dw;
            d_wmask    = tbl[n].wm;
            d_address  = tbl[n].da;
            d_wdata    = tbl[n].dwd;
            pmem_rdata = tbl[n].prd;
            pmem_resp  = tbl[n].presp;
            #1;
            chk($sformatf("v%0d_pmem_read", n),  16'(pmem_read),  16'(tbl[n].e_rd));
            chk($sformatf("v%0d_pmem_write", n), 16'(pmem_write), 16'(tbl[n].e_wr));
            chk($sformatf("v%0d_pmem_wmask", n), 16'(pmem_wmask), 16'(tbl[n].e_wm));
            chk($sformatf("v%0d_pmem_addr", n),  pmem_address,    tbl[n].e_addr);
            chk($sformatf("v%0d_pmem_wdata", n), pmem_wdata,      tbl[n].e_wd);
            chk($sformatf("v%0d_i_resp", n),     16'(i_resp),     16'(tbl[n].e_iresp));
            chk($sformatf("v%0d_d_resp", n),     16'(d_resp),     16'(tbl[n].e_dresp));
            chk($sformatf("v%0d_i_rdata", n),    i_rdata,         tbl[n].prd);
            chk($sformatf("v%0d_d_rdata", n),    d_rdata,         tbl[n].prd);
        end

        // Contention: both sides request together; each drops after its quota.
`ifdef ARB_ROUND_ROBIN_EN
        rem_i = 2;
        rem_d = 1;
        exp_is_i[0] = 1'b1;
        exp_is_i[1] = 1'b0;
        exp_is_i[2] = 1'b1;
`else
        rem_i = 1;
        rem_d = 2;
        exp_is_i[0] = 1'b0;
        exp_is_i[1] = 1'b0;
        exp_is_i[2] = 1'b1;
`endif
        @(negedge clk);
        reset     = 1'b0;
        pmem_resp = 1'b0;
        i_read    = 1'b1;
        i_address = 16'h0A00;
        d_read    = 1'b1;
        d_write   = 1'b0;
        d_address = 16'h0D00;
        for (int t = 0; t < 3; t++) begin
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge clk);
                #1;
                if (pmem_read) found = 1'b1;
            end
            if (!found) begin
                chk($sformatf("contend%0d_grant_timeout", t), 16'(pmem_read), 16'h1);
            end else begin
                got_i = (pmem_address == 16'h0A00);
                chk($sformatf("contend%0d_grant_is_i", t), 16'(got_i), 16'(exp_is_i[t]));
                pmem_resp  = 1'b1;
                pmem_rdata = 16'(t + 16'h00C0);
                #1;
                chk($sformatf("contend%0d_i_resp", t), 16'(i_resp), 16'(exp_is_i[t]));
                chk($sformatf("contend%0d_d_resp", t), 16'(d_resp), 16'(!exp_is_i[t]));
                @(negedge clk);
                pmem_resp = 1'b0;
                if (got_i) begin
                    rem_i--;
                    if (rem_i <= 0) i_read = 1'b0;
                end else begin
                    rem_d--;
                    if (rem_d <= 0) d_read = 1'b0;
                end
                #1;
                chk($sformatf("contend%0d_released", t), 16'(pmem_read), 16'h0);
            end
        end
        i_read = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
